// File: rtl/hazard_scoreboard_if.sv
// ID-stage instruction fields going into the hazard scoreboard, and the stall and
// forwarding controls it hands back to the pipeline.
interface hazard_scoreboard_if #(
  parameter int ADDR_W = 3
);
  logic              id_valid;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              rs_used;
  logic              rt_used;
  logic              id_wr_en;
  logic [ADDR_W-1:0] id_write_addr;
  logic              id_is_load;
  logic              flush;
  logic              stall_pc;
  logic              stall_ifid;
  logic              bubble;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [15:0]       stall_count;

  modport master (
    output id_valid, rs_addr, rt_addr, rs_used, rt_used,
           id_wr_en, id_write_addr, id_is_load, flush,
    input  stall_pc, stall_ifid, bubble, fwd_a_sel, fwd_b_sel, stall_count
  );

  modport slave (
    input  id_valid, rs_addr, rt_addr, rs_used, rt_used,
           id_wr_en, id_write_addr, id_is_load, flush,
    output stall_pc, stall_ifid, bubble, fwd_a_sel, fwd_b_sel, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard detection and stall control for the 5-stage pipeline: tracks in-flight
// writers in EX/MEM/WB, stalls the ID instruction on a hazard and emits forwarding selects.
module hazard_scoreboard #(
  parameter int ADDR_W      = 3,
  parameter int FWD_EN      = 0,
  parameter int RF_BYPASS   = 1,
  parameter int ZERO_REG_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave bus
);

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] addr;
    logic              ld;
  } sb_entry_t;

  sb_entry_t   ex_q, mem_q, wb_q, ex_next;
  logic        a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
  logic        hazard, hazard_q;
  logic [1:0]  fwd_a_next, fwd_b_next, fwd_a_q, fwd_b_q;
  logic [15:0] stall_cnt_q;

  // Register 0 reads are never dependent when it is hard-wired to zero.
  function automatic logic src_match(input logic used, input logic [ADDR_W-1:0] src,
                                     input sb_entry_t e);
    logic zero_src;
    zero_src = (ZERO_REG_EN != 0) && (src == '0);
    return used && e.v && (e.addr == src) && !zero_src;
  endfunction

  // The youngest producer wins, so an EX hit takes priority over MEM.
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
    if (hit_ex)
      return 2'b01;
    else if (hit_mem)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  always_comb begin
    a_ex  = src_match(bus.rs_used, bus.rs_addr, ex_q);
    a_mem = src_match(bus.rs_used, bus.rs_addr, mem_q);
    a_wb  = src_match(bus.rs_used, bus.rs_addr, wb_q);
    b_ex  = src_match(bus.rt_used, bus.rt_addr, ex_q);
    b_mem = src_match(bus.rt_used, bus.rt_addr, mem_q);
    b_wb  = src_match(bus.rt_used, bus.rt_addr, wb_q);

    if (FWD_EN != 0)
      hazard = (a_ex | b_ex) & ex_q.ld;
    else
      hazard = a_ex | a_mem | b_ex | b_mem;
    if (RF_BYPASS == 0)
      hazard = hazard | a_wb | b_wb;

    hazard_q = bus.id_valid & hazard & ~bus.flush;

    fwd_a_next = 2'b00;
    fwd_b_next = 2'b00;
    if ((FWD_EN != 0) && bus.id_valid && !bus.flush && !hazard_q) begin
      fwd_a_next = fwd_sel(a_ex, a_mem);
      fwd_b_next = fwd_sel(b_ex, b_mem);
    end

    // A stalled or squashed slot enters EX as an invalid entry so the stall drains by itself.
    ex_next.v    = bus.id_valid && bus.id_wr_en && !hazard_q && !bus.flush &&
                   !((ZERO_REG_EN != 0) && (bus.id_write_addr == '0));
    ex_next.addr = bus.id_write_addr;
    ex_next.ld   = bus.id_is_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_cnt_q <= '0;
    end else begin
      ex_q    <= ex_next;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= fwd_a_next;
      fwd_b_q <= fwd_b_next;
      if (hazard_q && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_pc    = hazard_q;
  assign bus.stall_ifid  = hazard_q;
  assign bus.bubble      = hazard_q;
  assign bus.fwd_a_sel   = fwd_a_q;
  assign bus.fwd_b_sel   = fwd_b_q;
  assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: three parameterisations share one input stream;
// the driver queues hand-computed expectations and a negedge monitor pops and compares them.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.ADDR_W(3)) bus0 ();
  hazard_scoreboard_if #(.ADDR_W(3)) bus1 ();
  hazard_scoreboard_if #(.ADDR_W(3)) bus2 ();

  // u0: stall on any writer; u1: forwarding, load-use only; u2: no RF write-through
  hazard_scoreboard #(.ADDR_W(3), .FWD_EN(0), .RF_BYPASS(1), .ZERO_REG_EN(1)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  hazard_scoreboard #(.ADDR_W(3), .FWD_EN(1), .RF_BYPASS(1), .ZERO_REG_EN(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  hazard_scoreboard #(.ADDR_W(3), .FWD_EN(0), .RF_BYPASS(0), .ZERO_REG_EN(1)) u2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    int          inst;
    int          step;
    logic        bubble;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;

  task automatic checkOutput(input string name, input int step, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, step, actual, expected);
    end
  endtask

  task automatic driveInputs(input int v, input int rs, input int rt, input int ru, input int tu,
                             input int we, input int wa, input int ld, input int fl);
    bus0.id_valid = 1'(v);      bus1.id_valid = 1'(v);      bus2.id_valid = 1'(v);
    bus0.rs_addr = 3'(rs);      bus1.rs_addr = 3'(rs);      bus2.rs_addr = 3'(rs);
    bus0.rt_addr = 3'(rt);      bus1.rt_addr = 3'(rt);      bus2.rt_addr = 3'(rt);
    bus0.rs_used = 1'(ru);      bus1.rs_used = 1'(ru);      bus2.rs_used = 1'(ru);
    bus0.rt_used = 1'(tu);      bus1.rt_used = 1'(tu);      bus2.rt_used = 1'(tu);
    bus0.id_wr_en = 1'(we);     bus1.id_wr_en = 1'(we);     bus2.id_wr_en = 1'(we);
    bus0.id_write_addr = 3'(wa); bus1.id_write_addr = 3'(wa); bus2.id_write_addr = 3'(wa);
    bus0.id_is_load = 1'(ld);   bus1.id_is_load = 1'(ld);   bus2.id_is_load = 1'(ld);
    bus0.flush = 1'(fl);        bus1.flush = 1'(fl);        bus2.flush = 1'(fl);
  endtask

  // One cycle: present the ID instruction and queue what instance `inst` should show this cycle.
  task automatic applyStimulus(input int inst, input int v, input int rs, input int rt,
                               input int ru, input int tu, input int we, input int wa,
                               input int ld, input int fl, input int eb, input int efa,
                               input int efb, input int ecnt);
    exp_t e;
    driveInputs(v, rs, rt, ru, tu, we, wa, ld, fl);
    step_no++;
    e.inst   = inst;
    e.step   = step_no;
    e.bubble = 1'(eb);
    e.fa     = 2'(efa);
    e.fb     = 2'(efb);
    e.cnt    = 16'(ecnt);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(input int inst, input int efa, input int efb, input int ecnt);
    applyStimulus(inst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, efa, efb, ecnt);
  endtask

  task automatic doReset();
    rst = 1'b1;
    driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t        e;
    logic        b, sp, si;
    logic [1:0]  fa, fb;
    logic [15:0] cnt;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        case (e.inst)
          0: begin b = bus0.bubble; sp = bus0.stall_pc; si = bus0.stall_ifid;
                   fa = bus0.fwd_a_sel; fb = bus0.fwd_b_sel; cnt = bus0.stall_count; end
          1: begin b = bus1.bubble; sp = bus1.stall_pc; si = bus1.stall_ifid;
                   fa = bus1.fwd_a_sel; fb = bus1.fwd_b_sel; cnt = bus1.stall_count; end
          default: begin b = bus2.bubble; sp = bus2.stall_pc; si = bus2.stall_ifid;
                   fa = bus2.fwd_a_sel; fb = bus2.fwd_b_sel; cnt = bus2.stall_count; end
        endcase
        checkOutput("bubble", e.step, 16'(b), 16'(e.bubble));
        checkOutput("stall_pc", e.step, 16'(sp), 16'(e.bubble));
        checkOutput("stall_ifid", e.step, 16'(si), 16'(e.bubble));
        checkOutput("fwd_a_sel", e.step, 16'(fa), 16'(e.fa));
        checkOutput("fwd_b_sel", e.step, 16'(fb), 16'(e.fb));
        checkOutput("stall_count", e.step, cnt, e.cnt);
      end
    end
  end

  // Args: inst, valid, rs, rt, rs_used, rt_used, wr_en, wr_addr, is_load, flush | bubble, fa, fb, count
  initial begin : driver
    doReset();
    idleCycle(0, 0, 0, 0);
    idleCycle(1, 0, 0, 0);

    $display("[TB] back-to-back ALU dependency, no forwarding");
    applyStimulus(0, 1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 3, 1, 1, 1, 1, 4, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 3, 1, 1, 1, 1, 4, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 1, 3, 1, 1, 1, 1, 4, 0, 0, 0, 0, 0, 2);
    idleCycle(0, 0, 0, 2);

    $display("[TB] register 0 writer then reader");
    applyStimulus(0, 1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 2);
    applyStimulus(0, 1, 0, 0, 1, 1, 1, 5, 0, 0, 0, 0, 0, 2);
    idleCycle(0, 0, 0, 2);

    $display("[TB] load-use with forwarding");
    doReset();
    applyStimulus(1, 1, 1, 0, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 2, 2, 1, 1, 1, 5, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 2, 2, 1, 1, 1, 5, 0, 0, 0, 0, 0, 1);
    idleCycle(1, 2, 2, 1);
    idleCycle(1, 0, 0, 1);

    $display("[TB] youngest producer forwarding, r0 ignored");
    doReset();
    applyStimulus(1, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 4, 5, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0);
    idleCycle(1, 1, 0, 0);

    $display("[TB] load-use hazard squashed by flush");
    doReset();
    applyStimulus(1, 1, 1, 0, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 2, 2, 1, 1, 1, 5, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 5, 2, 1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
    idleCycle(1, 0, 2, 0);

    $display("[TB] dependency without register-file write-through");
    doReset();
    applyStimulus(2, 1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
    applyStimulus(2, 1, 3, 1, 1, 1, 1, 4, 0, 0, 1, 0, 0, 0);
    applyStimulus(2, 1, 3, 1, 1, 1, 1, 4, 0, 0, 1, 0, 0, 1);
    applyStimulus(2, 1, 3, 1, 1, 1, 1, 4, 0, 0, 1, 0, 0, 2);
    applyStimulus(2, 1, 3, 1, 1, 1, 1, 4, 0, 0, 0, 0, 0, 3);
    idleCycle(2, 0, 0, 3);

    $display("[TB] reset in the middle of a stall");
    doReset();
    applyStimulus(0, 1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 3, 1, 1, 1, 1, 4, 0, 0, 1, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(0, 1, 3, 1, 1, 1, 1, 4, 0, 0, 1, 0, 0, 1);
    rst = 1'b0;
    applyStimulus(0, 1, 3, 1, 1, 1, 1, 4, 0, 0, 0, 0, 0, 0);
    idleCycle(0, 0, 0, 0);

    $display("[TB] stall counter saturation");
    doReset();
    force u0.stall_cnt_q = 16'hFFFE;
    #1;
    release u0.stall_cnt_q;
    applyStimulus(0, 1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0, 32'hFFFE);
    applyStimulus(0, 1, 3, 1, 1, 1, 1, 4, 0, 0, 1, 0, 0, 32'hFFFE);
    applyStimulus(0, 1, 3, 1, 1, 1, 1, 4, 0, 0, 1, 0, 0, 32'hFFFF);
    applyStimulus(0, 1, 3, 1, 1, 1, 1, 4, 0, 0, 0, 0, 0, 32'hFFFF);
    idleCycle(0, 0, 0, 32'hFFFF);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Hazard detection and stall controller for the 16-bit 5-stage pipeline.
- Tracks the destinations of in-flight register writes for EX, MEM and WB in an internal scoreboard.
- Compares the sources of the instruction in ID against that scoreboard, then drives stall_pc, stall_ifid and bubble into the ID/EX register's control-zeroing select.
- Optionally produces registered forwarding selects that travel with the instruction into EX.

Parameters:
- ADDR_W, 3: register address width; 8 architectural registers.
- FWD_EN, 0: 1 enables forwarding, so only load-use hazards stall. 0 stalls on any pending writer.
- RF_BYPASS, 1: 1 means the register file is write-through, so a writer in WB never causes a hazard.
- ZERO_REG_EN, 1: 1 means register 0 is hard-wired zero and never hazards.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- id_valid, input, 1: the ID stage holds a real instruction.
- rs_addr, input, ADDR_W: ID source A address.
- rt_addr, input, ADDR_W: ID source B address.
- rs_used, input, 1: the instruction reads source A.
- rt_used, input, 1: the instruction reads source B.
- id_wr_en, input, 1: the ID instruction writes the register file.
- id_write_addr, input, ADDR_W: ID destination address.
- id_is_load, input, 1: the ID instruction writes back from memory.
- flush, input, 1: branch taken; squash the ID instruction.
- stall_pc, output, 1: hold the PC (combinational).
- stall_ifid, output, 1: hold the IF/ID register (combinational).
- bubble, output, 1: zero the ID/EX control fields this cycle (combinational).
- fwd_a_sel, output, 2: registered; EX source A select. 00 = RF, 01 = MEM-stage result, 10 = WB-stage result.
- fwd_b_sel, output, 2: registered; same encoding for source B.
- stall_count, output, 16: registered, saturating count of stall cycles.

Behaviour:
- Scoreboard: three entries, EX, MEM and WB. Each entry holds {v, addr[ADDR_W], ld}.
- Every cycle the entries shift: WB <= MEM, MEM <= EX.
- EX <= {id_valid & id_wr_en & ~bubble & ~flush & ~(ZERO_REG_EN & id_write_addr==0), id_write_addr, id_is_load}.
- Source match:
  - match(src, E) = used & E.v & (E.addr==src).
  - Suppressed when ZERO_REG_EN and src==0.
- Hazard when FWD_EN=0:
  - Any used source matches EX or MEM.
  - When RF_BYPASS=0, a match on WB is also a hazard.
- Hazard when FWD_EN=1:
  - Any used source matches EX with EX.ld=1 (load-use).
  - When RF_BYPASS=0, a match on WB is also a hazard.
- Stall outputs:
  - hazard_q = id_valid & hazard & ~flush.
  - stall_pc = stall_ifid = bubble = hazard_q.
  - flush alone does not assert stall_*. The branch logic squashes IF/ID itself.
  - The bubble inserted into EX is an invalid scoreboard entry, so the stall resolves without external help.
- Stall duration:
  - FWD_EN=0: a dependency on the immediately preceding instruction stalls 2 cycles (1 when RF_BYPASS=0 would add one more for WB, giving 3).
  - FWD_EN=1: a load-use dependency stalls exactly 1 cycle.
- Forward selects (FWD_EN=1 only), computed in ID and registered on the same edge the instruction enters EX:
  - Producer currently in EX (non-load) -> 01.
  - Else producer in MEM -> 10.
  - Else 00.
  - The youngest producer wins.
  - Forced to 00 when bubble, flush or ~id_valid.
  - Tied to 00 when FWD_EN=0.
- stall_count increments on each cycle with hazard_q=1 and saturates at 16'hFFFF.
- Reset:
  - Clears all scoreboard valids, fwd_a_sel/fwd_b_sel and stall_count to 0.
  - Combinational outputs therefore read 0 in the cycle after reset.
  - Reset asserted mid-stall drops the stall on the next edge; pending writers are forgotten.
- Simultaneous events:
  - flush with a hazard: flush wins; no stall, and EX receives an invalid entry.
  - id_valid=0: no hazard and an invalid entry.
  - A source matching both EX and MEM is a single hazard; the EX match governs.
  - An instruction reading its own destination register is not a self-hazard.

Test Plan:
1. FWD_EN=0: ADD r3 then ADD r4,r3,r1 back-to-back -> bubble=1 for 2 cycles; stall_count=2; the consumer issues on cycle 3.
2. FWD_EN=1: LW r2 then ADD r5,r2,r2 -> bubble=1 for exactly 1 cycle; the consumer enters EX with fwd_a_sel=fwd_b_sel=10.
3. FWD_EN=1: ADD r1; ADD r1; SUB r6,r1,r0 -> no stall; fwd_a_sel=01 (youngest producer); fwd_b_sel=00 because r0 is ignored.
4. Writer to r0, then a reader of r0 (ZERO_REG_EN=1) -> no bubble; stall_count unchanged.
5. Load-use hazard with flush=1 in the same cycle -> bubble=0; the EX entry is invalid; the next instruction has no stall.
6. Mid-stall rst=1 for one cycle -> all outputs 0 the next cycle; stall_count=0; the scoreboard is empty. Force stall_count to FFFF and stall once more -> it stays FFFF.
